// File: rtl/gpio_bus_ctrl.sv
// Register front end for the 32-pin GPIO block: direction/output shadows, atomic
// set/clear/toggle, GPIO write strobes and a maskable edge interrupt.
module gpio_bus_ctrl #(
  parameter logic [31:0] DDIR_RST = 32'hFFFF_FFFF,
  parameter logic [31:0] DOUT_RST = 32'h0000_0000,
  parameter int          IRQ_EDGE = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic [2:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic [31:0] o_gpio_ddir,
  output logic [31:0] o_gpio_dout,
  output logic        o_gpio_wer,
  output logic        o_gpio_weo,
  input  logic [31:0] i_gpio_din,
  output logic        o_irq
);

  typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

  state_t      state, state_next;
  logic [31:0] ddir_q, dout_q, ien_q, pend_q, din_q;
  logic [31:0] ddir_d, dout_d, ien_d, pend_d, rdata_d;
  logic [31:0] rise, fall, edge_sel, edge_hit, w1c;
  logic        ready_d, wer_d, weo_d;
  logic        edge_ok_q;
  logic        rdata_en;

  assign rise = i_gpio_din & ~din_q;
  assign fall = ~i_gpio_din & din_q;

  always_comb begin
    case (IRQ_EDGE)
      0:       edge_sel = rise;
      1:       edge_sel = fall;
      default: edge_sel = rise | fall;
    endcase
  end

  // The first sample after reset only primes din_q; it must not look like an edge.
  assign edge_hit = edge_ok_q ? (edge_sel & ddir_q) : 32'h0;

  always_comb begin
    state_next = state;
    ready_d    = 1'b0;
    wer_d      = 1'b0;
    weo_d      = 1'b0;
    rdata_en   = 1'b0;
    rdata_d    = 32'h0;
    ddir_d     = ddir_q;
    dout_d     = dout_q;
    ien_d      = ien_q;
    w1c        = 32'h0;
    case (state)
      INIT: begin
        wer_d      = 1'b1;
        weo_d      = 1'b1;
        state_next = IDLE;
      end
      IDLE: begin
        if (i_sel) begin
          ready_d    = 1'b1;
          state_next = RESP;
          if (i_we) begin
            case (i_addr)
              3'd0: begin ddir_d = i_wdata;           wer_d = 1'b1; end
              3'd1: begin dout_d = i_wdata;           weo_d = 1'b1; end
              3'd2: begin dout_d = dout_q | i_wdata;  weo_d = 1'b1; end
              3'd3: begin dout_d = dout_q & ~i_wdata; weo_d = 1'b1; end
              3'd4: begin dout_d = dout_q ^ i_wdata;  weo_d = 1'b1; end
              3'd6: ien_d = i_wdata;
              3'd7: w1c   = i_wdata;
              default: ;
            endcase
          end else begin
            rdata_en = 1'b1;
          end
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = INIT;
    endcase

    if (rdata_en) begin
      case (i_addr)
        3'd0:    rdata_d = ddir_q;
        3'd1:    rdata_d = dout_q;
        3'd5:    rdata_d = i_gpio_din;
        3'd6:    rdata_d = ien_q;
        3'd7:    rdata_d = pend_q;
        default: rdata_d = 32'h0;
      endcase
    end

    // A new edge beats a simultaneous write-one-to-clear on the same bit.
    pend_d = (pend_q & ~w1c) | edge_hit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= INIT;
      ddir_q     <= DDIR_RST;
      dout_q     <= DOUT_RST;
      ien_q      <= 32'h0;
      pend_q     <= 32'h0;
      din_q      <= 32'h0;
      edge_ok_q  <= 1'b0;
      o_rdata    <= 32'h0;
      o_ready    <= 1'b0;
      o_gpio_wer <= 1'b0;
      o_gpio_weo <= 1'b0;
      o_irq      <= 1'b0;
    end else begin
      state      <= state_next;
      ddir_q     <= ddir_d;
      dout_q     <= dout_d;
      ien_q      <= ien_d;
      pend_q     <= pend_d;
      din_q      <= i_gpio_din;
      edge_ok_q  <= 1'b1;
      o_rdata    <= rdata_d;
      o_ready    <= ready_d;
      o_gpio_wer <= wer_d;
      o_gpio_weo <= weo_d;
      o_irq      <= |(pend_q & ien_q);
    end
  end

  assign o_gpio_ddir = ddir_q;
  assign o_gpio_dout = dout_q;

endmodule

// File: tb/tb_gpio_bus_ctrl.sv
// Self-checking bench for gpio_bus_ctrl: directed register-map vectors, hand-built
// interrupt/reset corner cases, then random traffic against a transaction-level model.
module tb_gpio_bus_ctrl;

  localparam int TB_IRQ_EDGE = 0;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_sel;
  logic        i_we;
  logic [2:0]  i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic [31:0] o_gpio_ddir;
  logic [31:0] o_gpio_dout;
  logic        o_gpio_wer;
  logic        o_gpio_weo;
  logic [31:0] i_gpio_din;
  logic        o_irq;

  int checks;
  int failures;

  gpio_bus_ctrl #(
    .DDIR_RST(32'hFFFF_FFFF),
    .DOUT_RST(32'h0000_0000),
    .IRQ_EDGE(TB_IRQ_EDGE)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_sel(i_sel),
    .i_we(i_we),
    .i_addr(i_addr),
    .i_wdata(i_wdata),
    .o_rdata(o_rdata),
    .o_ready(o_ready),
    .o_gpio_ddir(o_gpio_ddir),
    .o_gpio_dout(o_gpio_dout),
    .o_gpio_wer(o_gpio_wer),
    .o_gpio_weo(o_gpio_weo),
    .i_gpio_din(i_gpio_din),
    .o_irq(o_irq)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] din;
    logic        hold;
    logic [31:0] exp_rdata;
    logic        exp_wer;
    logic        exp_weo;
    logic [31:0] exp_ddir;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full bus access: request, check the RESP cycle, then check the return to idle.
  task automatic applyStimulus(input vec_t v);
    i_gpio_din = v.din;
    i_sel      = 1'b1;
    i_we       = v.we;
    i_addr     = v.addr;
    i_wdata    = v.wdata;
    @(posedge i_clk); #1;
    if (!v.hold) i_sel = 1'b0;
    checkOutput("ready", {31'h0, o_ready}, 32'h1);
    checkOutput("rdata", o_rdata, v.exp_rdata);
    checkOutput("wer", {31'h0, o_gpio_wer}, {31'h0, v.exp_wer});
    checkOutput("weo", {31'h0, o_gpio_weo}, {31'h0, v.exp_weo});
    checkOutput("ddir", o_gpio_ddir, v.exp_ddir);
    checkOutput("dout", o_gpio_dout, v.exp_dout);
    @(posedge i_clk); #1;
    i_sel = 1'b0;
    checkOutput("ready_idle", {31'h0, o_ready}, 32'h0);
    checkOutput("rdata_idle", o_rdata, 32'h0);
    checkOutput("strobes_idle", {30'h0, o_gpio_wer, o_gpio_weo}, 32'h0);
  endtask

  // Transaction-level reference model state.
  logic [31:0] m_ddir, m_dout, m_ien, m_pend, m_din_prev;
  logic        m_started, m_busy, m_prev_ok;
  logic [31:0] e_rdata;
  logic        e_ready, e_wer, e_weo, e_irq;

  task automatic modelReset();
    m_ddir     = 32'hFFFF_FFFF;
    m_dout     = 32'h0;
    m_ien      = 32'h0;
    m_pend     = 32'h0;
    m_din_prev = 32'h0;
    m_started  = 1'b0;
    m_busy     = 1'b0;
    m_prev_ok  = 1'b0;
  endtask

  // Predicts the outputs seen just after the coming clock edge from the current inputs.
  task automatic modelStep();
    logic        acc;
    logic [31:0] edges, clr;
    acc     = i_sel && m_started && !m_busy;
    e_ready = acc;
    e_irq   = (m_pend & m_ien) != 0;
    e_wer   = !m_started || (acc && i_we && i_addr == 3'd0);
    e_weo   = !m_started || (acc && i_we && i_addr >= 3'd1 && i_addr <= 3'd4);
    e_rdata = 32'h0;
    clr     = 32'h0;
    if (acc && !i_we) begin
      if (i_addr == 3'd0) e_rdata = m_ddir;
      else if (i_addr == 3'd1) e_rdata = m_dout;
      else if (i_addr == 3'd5) e_rdata = i_gpio_din;
      else if (i_addr == 3'd6) e_rdata = m_ien;
      else if (i_addr == 3'd7) e_rdata = m_pend;
    end
    if (TB_IRQ_EDGE == 0)      edges = i_gpio_din & ~m_din_prev;
    else if (TB_IRQ_EDGE == 1) edges = ~i_gpio_din & m_din_prev;
    else                       edges = i_gpio_din ^ m_din_prev;
    if (!m_prev_ok) edges = 32'h0;
    edges = edges & m_ddir;
    if (acc && i_we) begin
      if (i_addr == 3'd0) m_ddir = i_wdata;
      else if (i_addr == 3'd1) m_dout = i_wdata;
      else if (i_addr == 3'd2) m_dout = m_dout | i_wdata;
      else if (i_addr == 3'd3) m_dout = m_dout & ~i_wdata;
      else if (i_addr == 3'd4) m_dout = m_dout ^ i_wdata;
      else if (i_addr == 3'd6) m_ien = i_wdata;
      else if (i_addr == 3'd7) clr = i_wdata;
    end
    m_pend     = (m_pend & ~clr) | edges;
    m_din_prev = i_gpio_din;
    m_prev_ok  = 1'b1;
    m_busy     = acc;
    m_started  = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b1, 3'd1, 32'h0000_00F0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_00F0};
    vecs[1]  = '{1'b1, 3'd2, 32'h0000_000F, 32'h0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_00FF};
    vecs[2]  = '{1'b1, 3'd3, 32'h0000_0030, 32'h0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_00CF};
    vecs[3]  = '{1'b1, 3'd4, 32'h8000_0001, 32'h0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF, 32'h8000_00CE};
    vecs[4]  = '{1'b0, 3'd1, 32'h0,         32'h0, 1'b0, 32'h8000_00CE, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h8000_00CE};
    vecs[5]  = '{1'b1, 3'd0, 32'h0000_FFFF, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_FFFF, 32'h8000_00CE};
    vecs[6]  = '{1'b0, 3'd5, 32'h0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_FFFF, 32'h8000_00CE};
    vecs[7]  = '{1'b0, 3'd2, 32'h0, 32'h1234_5678, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_FFFF, 32'h8000_00CE};
    vecs[8]  = '{1'b1, 3'd5, 32'hDEAD, 32'h1234_5678, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0000_FFFF, 32'h8000_00CE};
    vecs[9]  = '{1'b1, 3'd6, 32'h0001_0001, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_FFFF, 32'h8000_00CE};
    vecs[10] = '{1'b0, 3'd6, 32'h0, 32'h1234_5678, 1'b0, 32'h0001_0001, 1'b0, 1'b0, 32'h0000_FFFF, 32'h8000_00CE};
    vecs[11] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_FFFF, 32'h8000_00CE};
    vecs[12] = '{1'b0, 3'd7, 32'h0,         32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_FFFF, 32'h8000_00CE};
    vecs[13] = '{1'b0, 3'd0, 32'h0,         32'h0, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 32'h0000_FFFF, 32'h8000_00CE};

    i_rst_n    = 1'b0;
    i_sel      = 1'b0;
    i_we       = 1'b0;
    i_addr     = 3'd0;
    i_wdata    = 32'h0;
    i_gpio_din = 32'h0;

    // Reset state, then the INIT strobe on the first cycle out of reset.
    #13;
    checkOutput("rst_ready", {31'h0, o_ready}, 32'h0);
    checkOutput("rst_strobes", {30'h0, o_gpio_wer, o_gpio_weo}, 32'h0);
    checkOutput("rst_ddir", o_gpio_ddir, 32'hFFFF_FFFF);
    checkOutput("rst_dout", o_gpio_dout, 32'h0);
    checkOutput("rst_irq", {31'h0, o_irq}, 32'h0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("init_strobes", {30'h0, o_gpio_wer, o_gpio_weo}, 32'h3);
    @(posedge i_clk); #1;
    checkOutput("init_strobes_off", {30'h0, o_gpio_wer, o_gpio_weo}, 32'h0);

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

    // Rising edge on an input pin (0) and on an output pin (16).
    i_gpio_din = 32'h0001_0001;
    @(posedge i_clk); #1;
    checkOutput("irq_lag", {31'h0, o_irq}, 32'h0);
    @(posedge i_clk); #1;
    checkOutput("irq_set", {31'h0, o_irq}, 32'h1);
    applyStimulus('{1'b0, 3'd7, 32'h0, 32'h0001_0001, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_FFFF, 32'h8000_00CE});

    // W1C colliding with a fresh edge keeps the bit; a later W1C clears it.
    i_gpio_din = 32'h0001_0000;
    @(posedge i_clk); #1;
    applyStimulus('{1'b1, 3'd7, 32'h1, 32'h0001_0001, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_FFFF, 32'h8000_00CE});
    applyStimulus('{1'b0, 3'd7, 32'h0, 32'h0001_0001, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_FFFF, 32'h8000_00CE});
    checkOutput("irq_kept", {31'h0, o_irq}, 32'h1);
    applyStimulus('{1'b1, 3'd7, 32'h1, 32'h0001_0001, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_FFFF, 32'h8000_00CE});
    checkOutput("irq_cleared", {31'h0, o_irq}, 32'h0);
    applyStimulus('{1'b0, 3'd7, 32'h0, 32'h0001_0001, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_FFFF, 32'h8000_00CE});

    // Reset while in RESP drops the ack and restores the shadows.
    i_sel   = 1'b1;
    i_we    = 1'b1;
    i_addr  = 3'd0;
    i_wdata = 32'h1234_5678;
    @(posedge i_clk); #1;
    i_sel = 1'b0;
    checkOutput("pre_rst_ready", {31'h0, o_ready}, 32'h1);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", {31'h0, o_ready}, 32'h0);
    checkOutput("midrst_ddir", o_gpio_ddir, 32'hFFFF_FFFF);
    checkOutput("midrst_dout", o_gpio_dout, 32'h0);
    checkOutput("midrst_strobes", {30'h0, o_gpio_wer, o_gpio_weo}, 32'h0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("reinit_strobes", {30'h0, o_gpio_wer, o_gpio_weo}, 32'h3);
    checkOutput("reinit_ready", {31'h0, o_ready}, 32'h0);

    // Random traffic from a fresh reset against the reference model.
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    modelReset();
    for (int c = 0; c < 400; c++) begin
      i_sel      = ($urandom_range(0, 1) == 1);
      i_we       = ($urandom_range(0, 1) == 1);
      i_addr     = 3'($urandom_range(0, 7));
      i_wdata    = $urandom;
      i_gpio_din = i_gpio_din ^ ($urandom & $urandom & $urandom);
      modelStep();
      @(posedge i_clk); #1;
      checkOutput("rnd_ready", {31'h0, o_ready}, {31'h0, e_ready});
      checkOutput("rnd_rdata", o_rdata, e_rdata);
      checkOutput("rnd_wer", {31'h0, o_gpio_wer}, {31'h0, e_wer});
      checkOutput("rnd_weo", {31'h0, o_gpio_weo}, {31'h0, e_weo});
      checkOutput("rnd_ddir", o_gpio_ddir, m_ddir);
      checkOutput("rnd_dout", o_gpio_dout, m_dout);
      checkOutput("rnd_irq", {31'h0, o_irq}, {31'h0, e_irq});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
